matvec_seq: RTL and testbench
=============================

# matvec_seq

Sequential signed fixed-point matrix-vector multiplier that consumes the packed N×N result of the `matinv<n>` inverter and computes x = M·b, with one multiply-accumulate per clock. It sits directly downstream of the inverter in the navigation solve path and turns an inverse plus right-hand side into a solution vector. The inverter is combinational; this block registers its operands on acceptance, so the upstream matrix may change after the handshake.

## Interface

Parameters:
- `DATA_WIDTH`, 16: width of every matrix/vector element, two's complement.
- `MATRIX_SIZE`, 3: N, the matrix dimension; must be ≥ 2.
- `FRAC_BITS`, 0: fractional bits of the fixed-point format; 0 means plain integers.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands valid.
- `in_ready` output 1: block can accept operands.
- `matrix` input N·N·DATA_WIDTH: element (r,c) at bits `[(r*N+c)*DATA_WIDTH +: DATA_WIDTH]`; same packing as the `matinv` output.
- `vector` input N·DATA_WIDTH: element i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `result` output N·DATA_WIDTH: x, packed like `vector`.
- `sat` output 1: at least one element of the current result saturated.

## Operation

- FSM states IDLE, MAC, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `matrix` and `vector`, clear row/col counters and the accumulator, clear `sat`, go to MAC.
- MAC, once per cycle: acc += M[row][col]·v[col].
  - col wraps N-1→0.
  - On col==N-1, the final sum (including this cycle's product) is scaled and written to result[row]. acc clears and row increments.
  - On row==N-1 && col==N-1, go to DONE.
- DONE: `out_valid`=1. `result` and `sat` are held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- `in_ready`=0 in MAC and DONE. `in_valid` is ignored there and causes no capture.
- Arithmetic:
  - Product is 2·DATA_WIDTH bits, signed.
  - Accumulator is 2·DATA_WIDTH+$clog2(N)+1 bits; it never overflows.
  - Scaling is an arithmetic right shift by FRAC_BITS, rounding toward −∞.
  - The scaled value is narrowed to DATA_WIDTH according to Configuration.
- Result elements not yet written in the current operation keep their previous values. They are only observable after DONE, where all N are fresh.

## Timing

- Reset (asynchronous assert, synchronous-safe release) puts outputs in this state: state=IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `sat`=0, counters and accumulator 0.
- Reset mid-MAC or mid-DONE aborts the operation; no partial result is emitted.
- Latency: with accept at edge k, `out_valid` rises after edge k+N·N. For N=3 that is 9 cycles.
- Throughput: one operation per N·N+2 cycles when `out_ready` is held high.
- No combinational path from `in_valid` or `out_ready` to any output. `in_ready` and `out_valid` decode directly from registered state.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Configuration

- Macro: `MATVEC_SAT_EN`.
- Defined: each scaled value outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] clamps to the nearest bound and sets sticky `sat` for that operation.
- Undefined: the low DATA_WIDTH bits are kept (two's-complement wrap) and `sat` is tied to 0.

## Test plan

1. Identity matrix with b=[1,2,3] (N=3, W=16, F=0): result=[1,2,3] and `out_valid` exactly 9 cycles after accept.
2. M=[[1,2,3],[4,5,6],[7,8,9]], b=[1,−1,2]: result=[5,11,17], `sat`=0.
3. Backpressure: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with new operands. Required: `result` stable, `in_ready`=0, no capture. Release `out_ready`, then the new operands are accepted the cycle after IDLE is reached.
4. All elements 32767, b=[32767]×3. With `MATVEC_SAT_EN`: result=[32767]×3 and `sat`=1. Without it: result=[0x0003]×3 and `sat`=0.
5. Reset mid-operation: assert `rst_n`=0 four cycles after accept. Required: `out_valid`=0, `result`=0, `in_ready`=1 after release. A following test 2 operation then completes correctly.
6. FRAC_BITS=8: M=256·I (1.0), b=[−384,128,0] (−1.5, 0.5, 0): result=[−384,128,0].

Source files
------------

// File: rtl/matvec_seq.sv
// Sequential signed fixed-point matrix-vector multiplier (x = M*b), one MAC per clock.
// Optional feature: define MATVEC_SAT_EN to clamp out-of-range results and report sticky sat.
module matvec_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 3,
  parameter int FRAC_BITS   = 0
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix,
  input  logic [MATRIX_SIZE*DATA_WIDTH-1:0]         vector,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [MATRIX_SIZE*DATA_WIDTH-1:0]         result,
  output logic                                      sat
);
  localparam int N  = MATRIX_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(N);
  localparam int PW = 2 * W;
  localparam int AW = 2 * W + $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [AW-1:0] MAX_V = {{(AW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW - W + 1){1'b1}}, {(W - 1){1'b0}}};

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both 1;
  // in_ready is high only in IDLE, out_valid only in DONE, both decoded from state.
  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_next;

  logic [N*N*W-1:0]      m_q;
  logic [N*W-1:0]        v_q;
  logic signed [W-1:0]   m_arr [N][N];
  logic signed [W-1:0]   v_arr [N];
  logic [W-1:0]          res_q [N];
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         row, col;
  logic                  sat_q;

  logic signed [W-1:0]   m_el, v_el;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  sum, scaled;
  logic [W-1:0]          narrow;
  logic                  clip;

  for (genvar r = 0; r < N; r++) begin : g_unpack
    assign v_arr[r] = v_q[r*W +: W];
    assign result[r*W +: W] = res_q[r];
    for (genvar c = 0; c < N; c++) begin : g_col
      assign m_arr[r][c] = m_q[(r*N+c)*W +: W];
    end
  end

  assign m_el   = m_arr[row][col];
  assign v_el   = v_arr[col];
  assign prod   = $signed({{W{m_el[W-1]}}, m_el}) * $signed({{W{v_el[W-1]}}, v_el});
  assign sum    = acc + AW'(prod);
  assign scaled = sum >>> FRAC_BITS;

`ifdef MATVEC_SAT_EN
  always_comb begin
    narrow = scaled[W-1:0];
    clip   = 1'b0;
    if (scaled > MAX_V) begin
      narrow = MAX_V[W-1:0];
      clip   = 1'b1;
    end else if (scaled < MIN_V) begin
      narrow = MIN_V[W-1:0];
      clip   = 1'b1;
    end
  end
`else
  // Two's-complement wrap: the upper bits are simply dropped.
  logic unused_hi;
  assign unused_hi = ^{scaled[AW-1:W], MAX_V, MIN_V};
  assign narrow    = scaled[W-1:0];
  assign clip      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = MAC;
      MAC:     if (row == LAST && col == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      v_q   <= '0;
      acc   <= '0;
      row   <= '0;
      col   <= '0;
      sat_q <= 1'b0;
      for (int i = 0; i < N; i++) res_q[i] <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m_q   <= matrix;
          v_q   <= vector;
          acc   <= '0;
          row   <= '0;
          col   <= '0;
          sat_q <= 1'b0;
        end
        MAC: if (col == LAST) begin
          // Row complete: this cycle's product is folded in via sum.
          res_q[row] <= narrow;
          sat_q      <= sat_q | clip;
          acc        <= '0;
          col        <= '0;
          row        <= row + CW'(1);
        end else begin
          acc <= sum;
          col <= col + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sat       = sat_q;
endmodule

// File: tb/tb_matvec_seq.sv
// Randomized scoreboard bench for matvec_seq (N=3, W=16) with an integer and a FRAC_BITS=8 instance.
module tb_matvec_seq;
  localparam int N = 3;
  localparam int W = 16;
  localparam int MW = N * N * W;
  localparam int VW = N * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Integer DUT
  logic          in_valid = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid, sat;
  logic [MW-1:0] matrix = '0;
  logic [VW-1:0] vector = '0;
  logic [VW-1:0] result;

  matvec_seq #(.DATA_WIDTH(W), .MATRIX_SIZE(N), .FRAC_BITS(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .matrix(matrix), .vector(vector), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .sat(sat)
  );

  // Q8.8 DUT
  logic          f_in_valid = 1'b0, f_out_ready = 1'b1;
  logic          f_in_ready, f_out_valid, f_sat;
  logic [MW-1:0] f_matrix = '0;
  logic [VW-1:0] f_vector = '0;
  logic [VW-1:0] f_result;

  matvec_seq #(.DATA_WIDTH(W), .MATRIX_SIZE(N), .FRAC_BITS(8)) u_frac (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .matrix(f_matrix), .vector(f_vector), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .result(f_result), .sat(f_sat)
  );

  int cmp_n = 0;
  int fail_n = 0;
  logic [VW:0] exp_q[$];
  logic [VW:0] fexp_q[$];
  int accept_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    cmp_n++;
    if (act !== want) begin
      fail_n++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [VW-1:0] pk(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [MW-1:0] mat_diag(input int s);
    logic [MW-1:0] m = '0;
    for (int i = 0; i < N; i++) m[(i*N+i)*W +: W] = s[15:0];
    return m;
  endfunction

  function automatic logic [MW-1:0] mat_fill(input int v, input int step);
    logic [MW-1:0] m = '0;
    for (int i = 0; i < N * N; i++) begin
      int e = v + step * i;
      m[i*W +: W] = e[15:0];
    end
    return m;
  endfunction

  // Reference: exact dot products, floor shift, then clamp or wrap.
  function automatic logic [VW:0] model(input logic [MW-1:0] m, input logic [VW-1:0] v,
                                        input int frac);
    logic [VW-1:0] r = '0;
    logic s = 1'b0;
    longint maxv = (longint'(1) <<< (W - 1)) - 1;
    longint minv = -maxv - 1;
    for (int i = 0; i < N; i++) begin
      longint a = 0;
      for (int j = 0; j < N; j++)
        a += longint'($signed(m[(i*N+j)*W +: W])) * longint'($signed(v[j*W +: W]));
      a = a >>> frac;
`ifdef MATVEC_SAT_EN
      if (a > maxv) begin a = maxv; s = 1'b1; end
      else if (a < minv) begin a = minv; s = 1'b1; end
`else
      if (maxv < minv) s = 1'b1;
`endif
      r[i*W +: W] = a[15:0];
    end
    return {s, r};
  endfunction

  function automatic logic [15:0] rnd_el(input int mode);
    case (mode)
      0:       return 16'($urandom_range(0, 200)) - 16'd100;
      1:       return 16'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
    endcase
  endfunction

  // Monitors: pop and compare whenever a result is handed over.
  logic [VW:0] e_main, e_frac;
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_ov) check("latency", 64'(cyc - accept_cyc), 64'(N * N));
    prev_ov = out_valid;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 64'(1), 64'(0));
      else begin
        e_main = exp_q.pop_front();
        check("result", {sat, result}, e_main);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && f_out_valid && f_out_ready) begin
      if (fexp_q.size() == 0) check("frac_unexpected_out", 64'(1), 64'(0));
      else begin
        e_frac = fexp_q.pop_front();
        check("frac_result", {f_sat, f_result}, e_frac);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [MW-1:0] m, input logic [VW-1:0] v, input logic [VW:0] e);
    int t = 0;
    while (!in_ready && t < 200) begin tick(); t++; end
    if (t >= 200) check("send_timeout", 64'(t), 64'(0));
    in_valid = 1'b1;
    matrix   = m;
    vector   = v;
    exp_q.push_back(e);
    tick();
    accept_cyc = cyc;
    in_valid   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin tick(); t++; end
    check("drain_timeout", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic fsend(input logic [MW-1:0] m, input logic [VW-1:0] v, input logic [VW:0] e);
    int t = 0;
    while (!f_in_ready && t < 200) begin tick(); t++; end
    f_in_valid = 1'b1;
    f_matrix   = m;
    f_vector   = v;
    fexp_q.push_back(e);
    tick();
    f_in_valid = 1'b0;
    t = 0;
    while (fexp_q.size() != 0 && t < 300) begin tick(); t++; end
    check("frac_timeout", 64'(fexp_q.size()), 64'(0));
    fexp_q.delete();
  endtask

  initial begin
    logic [MW-1:0] m, m2;
    logic [VW-1:0] v, v2;
    logic [VW:0]   e;
    int t;

    repeat (3) tick();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_sat", 64'(sat), 64'(0));
    rst_n = 1'b1;
    tick();

    // Identity and small integer matrix
    send(mat_diag(1), pk(1, 2, 3), {1'b0, pk(1, 2, 3)});
    drain();
    send(mat_fill(1, 1), pk(1, -1, 2), {1'b0, pk(5, 11, 17)});
    drain();

    // Backpressure in DONE with new operands offered
    out_ready = 1'b0;
    send(mat_fill(1, 1), pk(1, -1, 2), {1'b0, pk(5, 11, 17)});
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    check("bp_reach_done", 64'(out_valid), 64'(1));
    m2 = mat_diag(2);
    v2 = pk(7, -8, 9);
    in_valid = 1'b1;
    matrix   = m2;
    vector   = v2;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_hold", {out_valid, sat, result}, {2'b10, pk(5, 11, 17)});
    end
    out_ready = 1'b1;
    exp_q.push_back({1'b0, pk(14, -16, 18)});
    tick();
    check("bp_idle", 64'(in_ready), 64'(1));
    tick();
    accept_cyc = cyc;
    in_valid   = 1'b0;
    check("bp_captured", 64'(in_ready), 64'(0));
    drain();

    // Full-scale operands
`ifdef MATVEC_SAT_EN
    e = {1'b1, pk(32767, 32767, 32767)};
`else
    e = {1'b0, pk(3, 3, 3)};
`endif
    send(mat_fill(32767, 0), pk(32767, 32767, 32767), e);
    drain();

    // Reset mid-operation
    send(mat_fill(1, 1), pk(1, -1, 2), {1'b0, pk(5, 11, 17)});
    repeat (4) tick();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    tick();
    rst_n = 1'b1;
    tick();
    check("postrst_in_ready", 64'(in_ready), 64'(1));
    check("postrst_out_valid", 64'(out_valid), 64'(0));
    check("postrst_result", {sat, result}, '0);
    send(mat_fill(1, 1), pk(1, -1, 2), {1'b0, pk(5, 11, 17)});
    drain();

    // Randomized operations with random output stalls
    for (int n = 0; n < 40; n++) begin
      int mode = $urandom_range(0, 2);
      for (int i = 0; i < N * N; i++) m[i*W +: W] = rnd_el(mode);
      for (int i = 0; i < N; i++) v[i*W +: W] = rnd_el(mode);
      out_ready = ($urandom_range(0, 1) != 0);
      send(m, v, model(m, v, 0));
      if (!out_ready) begin
        repeat ($urandom_range(1, 15)) tick();
        out_ready = 1'b1;
      end
      drain();
    end

    // Q8.8: 1.0*I times [-1.5, 0.5, 0]
    fsend(mat_diag(256), pk(-384, 128, 0), {1'b0, pk(-384, 128, 0)});
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < N * N; i++) m[i*W +: W] = 16'($urandom_range(0, 1000)) - 16'd500;
      for (int i = 0; i < N; i++) v[i*W +: W] = 16'($urandom_range(0, 1000)) - 16'd500;
      fsend(m, v, model(m, v, 8));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
